fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage; consumes the current PC from the pc register and produces its next_pc.
//  Issues single-outstanding word reads on the instruction bus and holds each returned word in a
//  1-entry buffer with a valid/ready handshake to decode. Honours redirects (branch/jump/trap) any cycle.
// PARAMETERS
//  RESET_ADDR  32'h0000_0000  next_pc driven during reset/idle; must match pc register reset value
// PORTS
//  clk              in   1   system clock
//  rst              in   1   synchronous reset, active-high
//  pc               in   32  current PC (rv32::word) from pc register
//  next_pc          out  32  next PC (rv32::word) to pc register
//  ibus_req         out  1   read request valid
//  ibus_addr        out  32  read word address (= pc)
//  ibus_gnt         in   1   request accepted this cycle
//  ibus_rvalid      in   1   read data valid
//  ibus_rdata       in   32  read data
//  ibus_err         in   1   bus error, qualified by ibus_rvalid
//  redirect         in   1   flush and restart fetch at redirect_target
//  redirect_target  in   32  new fetch address
//  inst_valid       out  1   buffer holds an instruction
//  inst_ready       in   1   decode accepts (handshake when inst_valid && inst_ready)
//  inst             out  32  instruction word
//  inst_pc          out  32  address of inst
//  inst_fault       out  1   entry carries a fetch bus error
// BEHAVIOUR
//  Clock/reset: one clock clk; reset rst is synchronous, active-high.
//  Reset: state<=S_IDLE, buffer empty, kill<=0; outputs ibus_req=0, inst_valid=0, inst=0, inst_pc=0,
//   inst_fault=0, next_pc=RESET_ADDR (combinational, held during rst and S_IDLE).
//  FSM: S_IDLE -> S_REQ after 1 cycle. S_REQ: ibus_req=!redirect && (!inst_valid || inst_ready),
//   ibus_addr=pc; req&&gnt -> S_WAIT. S_WAIT: on ibus_rvalid -> S_REQ. S_HALT: see FETCH_BUS_ERR_EN.
//  next_pc: redirect ? {redirect_target[31:2],2'b00} : accept ? pc+4 (mod 2^32, wraps) : pc.
//   accept = S_WAIT && ibus_rvalid && !kill && !redirect; next_pc==pc otherwise (PC holds).
//  Buffer: on accept load inst=ibus_rdata, inst_pc=pc, inst_valid=1; cleared on handshake unless
//   reloaded same cycle. Request only issued when buffer empty or draining -> accept never overflows.
//   Latency: gnt cycle N, rvalid cycle >=N+1, inst_valid from N+2; peak 1 instr / 2 cycles.
//  Redirect: flushes buffer (inst_valid<=0) every state; ibus_req forced 0 that cycle (addr never
//   changes under an ungranted request). In S_WAIT without rvalid: kill<=1; response later
//   discarded, kill<=0. Redirect same cycle as rvalid: response discarded directly, kill unchanged.
//   Redirect same cycle as inst handshake: handshake counts as completed.
//  S_HALT: ibus_req=0; redirect -> S_REQ. ibus_rvalid outside S_WAIT is ignored.
//  Reset mid-operation: in-flight response is dropped (arrives outside S_WAIT).
// CONFIGURATION
//  FETCH_BUS_ERR_EN defined: accept with ibus_err loads inst=32'h0000_0013 (NOP), inst_fault=1,
//   next_pc=pc (no advance), state -> S_HALT until redirect. Errors on killed responses ignored.
//  Undefined: ibus_err ignored, inst_fault tied 0, S_HALT unreachable, data loaded as normal.
// STRUCTURE
//  lexington package: fetch_state_t {S_IDLE,S_REQ,S_WAIT,S_HALT}; RV_NOP=32'h0000_0013; INST_BYTES=4.
//  Sub-module fetch_buffer: 1-entry {inst,inst_pc,inst_fault} with load/flush/ready handshake.
//  FSM, kill flag, next_pc mux in fetch_unit.
// TESTING
//  1 Reset then gnt=1, rvalid 1 cycle later, rdata=32'h0000_0093 -> ibus_addr=0, inst_valid,
//    inst_pc=0, next_pc=4; ready=1 -> next req addr 4.
//  2 inst_ready=0 with buffer full -> ibus_req=0, next_pc==pc until handshake.
//  3 redirect to 32'h0000_0102 while S_WAIT -> next_pc=32'h100; late rvalid discarded
//    (inst_valid=0); next req addr 32'h100.
//  4 redirect coincident with rvalid -> no load, kill=0, next req at target.
//  5 pc=32'hFFFF_FFFC fetch accepted -> next_pc=32'h0000_0000.
//  6 FETCH_BUS_ERR_EN: rvalid+err at pc 8 -> inst=NOP, inst_fault=1, next_pc=8, no req until
//    redirect; undefined build -> normal load, inst_fault=0.

Source files
------------

// File: rtl/lexington_pkg.sv
// Shared types and constants for the lexington fetch stage.
package lexington_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RV_NOP     = 32'h0000_0013;
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry instruction holding buffer between the fetch bus and decode.
// A flush wins over a load; a load in the same cycle as a handshake refills the entry.
module fetch_buffer
  import lexington_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        ready_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic        fault_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);

  logic         valid_q;
  fetch_entry_t entry_q;

  // Entry state: flush, load, or drain on the decode handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q       <= 1'b1;
      entry_q.inst  <= inst_i;
      entry_q.pc    <= pc_i;
      entry_q.fault <= fault_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = entry_q.inst;
  assign pc_o    = entry_q.pc;
  assign fault_o = entry_q.fault;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding bus reads, 1-entry buffer, redirect handling.
// Optional feature macro: FETCH_BUS_ERR_EN (bus errors produce a faulting NOP and halt fetch).
module fetch_unit
  import lexington_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  fetch_state_t state_q;
  logic         kill_q;
  logic         accept_s;
  logic         err_s;
  logic [31:0]  target_s;
  logic [31:0]  load_inst_s;

  assign accept_s = (state_q == S_WAIT) && ibus_rvalid && !kill_q && !redirect;
  assign target_s = {redirect_target[31:2], 2'b00};

`ifdef FETCH_BUS_ERR_EN
  assign err_s = accept_s && ibus_err;
  logic [1:0] unused_s;
  assign unused_s = redirect_target[1:0];
`else
  assign err_s = 1'b0;
  logic [2:0] unused_s;
  assign unused_s = {ibus_err, redirect_target[1:0]};
`endif

  // Redirect suppresses the request so the address never moves under an ungranted request.
  assign ibus_req  = (state_q == S_REQ) && !redirect && (!inst_valid || inst_ready);
  assign ibus_addr = pc;
  assign load_inst_s = err_s ? RV_NOP : ibus_rdata;

  // Fetch control FSM with kill flag for responses made stale by a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (ibus_req && ibus_gnt) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ibus_rvalid) begin
            kill_q  <= 1'b0;
            state_q <= err_s ? S_HALT : S_REQ;
          end else if (redirect) begin
            kill_q <= 1'b1;
          end
        end
        S_HALT: begin
          if (redirect) begin
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_IDLE;
          kill_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next PC: redirect target, sequential advance on a clean accept, otherwise hold.
  always_comb begin
    next_pc = pc;
    if (rst) begin
      next_pc = RESET_ADDR;
    end else if (redirect) begin
      next_pc = target_s;
    end else if (state_q == S_IDLE) begin
      next_pc = RESET_ADDR;
    end else if (accept_s && !err_s) begin
      next_pc = pc + INST_BYTES;
    end else begin
      next_pc = pc;
    end
  end

  fetch_buffer u_buffer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept_s),
    .flush_i (redirect),
    .ready_i (inst_ready),
    .inst_i  (load_inst_s),
    .pc_i    (pc),
    .fault_i (err_s),
    .valid_o (inst_valid),
    .inst_o  (inst),
    .pc_o    (inst_pc),
    .fault_o (inst_fault)
  );

endmodule
